qspi_arb: RTL

Arbiter and sequencer for the single QSPI line-transfer engine shared by the instruction cache, the data cache and a DMA requester. It takes per-requester line-fill and write-back requests, picks one under fixed-priority-with-aging rules, holds the grant for the whole line transfer (including a data-cache push followed by pull), and presents one registered request to the QSPI engine. It sits between the cache miss logic and the QSPI engine in the top-level memory path.

---
 rtl/qspi_arb_pkg.sv | 44 ++++
 rtl/qspi_arb_pick.sv | 35 +++
 rtl/qspi_arb.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/qspi_arb_pkg.sv
// Shared definitions for the QSPI line-transfer arbiter.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package qspi_arb_pkg;

  // Sequencer states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT      = 3'd2;
  localparam logic [2:0] ST_PUSH_DONE = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  // Owner codes; also used as bit positions in the request/grant vectors
  localparam logic [1:0] OWN_I = 2'd0;
  localparam logic [1:0] OWN_D = 2'd1;
  localparam logic [1:0] OWN_X = 2'd2;

  // rom_mode encodings (chip-select policy)
  localparam logic [1:0] ROM_MSB_CS2 = 2'b00;  // tag MSB selects chip 2
  localparam logic [1:0] ROM_CS0     = 2'b01;  // everything on chip 0
  localparam logic [1:0] ROM_MSB_CS1 = 2'b10;  // tag MSB selects chip 1
  localparam logic [1:0] ROM_RW      = 2'b11;  // reads chip 1, writes chip 0

  // Saturating age counter width
  localparam int AGE_W = 3;

  function automatic int tag_width(input int pa, input int line_length);
    return pa - $clog2(line_length);
  endfunction

  // Chip-select index for one transfer
  function automatic logic [1:0] mem_sel(input logic [1:0] mode, input logic tag_msb,
                                         input logic write);
    logic [1:0] m;
    case (mode)
      ROM_MSB_CS2: m = tag_msb ? 2'd2 : 2'd0;
      ROM_CS0:     m = 2'd0;
      ROM_MSB_CS1: m = tag_msb ? 2'd1 : 2'd0;
      default:     m = write ? 2'd0 : 2'd1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/qspi_arb_pick.sv
// Aged fixed-priority selector: one-hot winner among I/D/X requests.
// Latency: combinational.
// Backpressure: none; caller decides when the result is used.
//
// Ports:
//   req  [2:0]        requests, indexed by OWN_I/OWN_D/OWN_X
//   age  [3*AGE_W-1:0] per-requester age counters, same indexing
//   win  [2:0]        one-hot winner, zero when no request
module qspi_arb_pick
  import qspi_arb_pkg::*;
#(
  parameter int AGE_MAX = 7
) (
  input  logic [2:0]         req,
  input  logic [3*AGE_W-1:0] age,
  output logic [2:0]         win
);

  logic [2:0] aged;
  logic [2:0] pool;

  always_comb begin
    aged = '0;
    for (int k = 0; k < 3; k++) begin
      aged[k] = req[k] && (age[k*AGE_W +: AGE_W] >= AGE_W'(AGE_MAX));
    end
    // Starved requesters compete only among themselves; otherwise plain priority
    pool = (|aged) ? aged : req;
    win  = '0;
    if (pool[OWN_D])      win[OWN_D] = 1'b1;
    else if (pool[OWN_I]) win[OWN_I] = 1'b1;
    else if (pool[OWN_X]) win[OWN_X] = 1'b1;
  end

endmodule

// File: rtl/qspi_arb.sv
// Arbitrates I/D/DMA line transfers onto one QSPI engine and sequences D push+pull.
// Latency: req -> grant 1 cycle, -> q_req 2 cycles; q_ack -> done 1 cycle.
// Backpressure: losers keep requesting and age; grant held until the owner's done.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   i_req/i_tag -> i_gnt/i_done  icache fill
//   d_req/d_push/d_tag/d_wtag -> d_gnt/d_done   dcache (optional write-back then fill)
//   x_req/x_write/x_tag -> x_gnt/x_done         DMA
//   rom_mode                     chip-select policy
//   q_req/q_write/q_i_d/q_mem/q_paddr, q_ack    QSPI engine handshake
//   err, err_clr                 sticky timeout flag and its clear
module qspi_arb
  import qspi_arb_pkg::*;
#(
  parameter int  PA          = 24,
  parameter int  LINE_LENGTH = 4,
  parameter int  AGE_MAX     = 7,
  parameter int  TIMEOUT     = 255,
  localparam int TW          = tag_width(PA, LINE_LENGTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_req,
  input  logic [TW-1:0] i_tag,
  output logic          i_gnt,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_push,
  input  logic [TW-1:0] d_tag,
  input  logic [TW-1:0] d_wtag,
  output logic          d_gnt,
  output logic          d_done,
  input  logic          x_req,
  input  logic          x_write,
  input  logic [TW-1:0] x_tag,
  output logic          x_gnt,
  output logic          x_done,
  input  logic [1:0]    rom_mode,
  output logic          q_req,
  output logic          q_write,
  output logic          q_i_d,
  output logic [1:0]    q_mem,
  output logic [TW-1:0] q_paddr,
  input  logic          q_ack,
  output logic          err,
  input  logic          err_clr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]            state;
  logic [1:0]            owner;
  logic                  push_phase;
  logic [TW-1:0]         fill_tag;
  logic [CW-1:0]         cnt;
  logic [2:0][AGE_W-1:0] age_q;
  logic [2:0]            req_vec;
  logic [2:0]            win;
  logic [1:0]            win_own;
  logic [TW-1:0]         sel_tag;
  logic                  sel_write;
  logic                  timeout;

  always_comb begin
    req_vec        = '0;
    req_vec[OWN_I] = i_req;
    req_vec[OWN_D] = d_req;
    req_vec[OWN_X] = x_req;
  end

  qspi_arb_pick #(.AGE_MAX(AGE_MAX)) u_pick (
    .req (req_vec),
    .age (age_q),
    .win (win)
  );

  // First transfer of the winner: D with a dirty victim writes it back first
  always_comb begin
    win_own   = OWN_I;
    sel_tag   = i_tag;
    sel_write = 1'b0;
    if (win[OWN_D]) begin
      win_own   = OWN_D;
      sel_tag   = d_push ? d_wtag : d_tag;
      sel_write = d_push;
    end else if (win[OWN_X]) begin
      win_own   = OWN_X;
      sel_tag   = x_tag;
      sel_write = x_write;
    end
  end

  // A late ack still counts; the abort only fires when the last cycle passes silently
  assign timeout = (state == ST_WAIT) && !q_ack && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_I;
      push_phase <= 1'b0;
      fill_tag   <= '0;
      cnt        <= '0;
      age_q      <= '0;
      i_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      x_gnt      <= 1'b0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      x_done     <= 1'b0;
      q_req      <= 1'b0;
      q_write    <= 1'b0;
      q_i_d      <= 1'b0;
      q_mem      <= '0;
      q_paddr    <= '0;
      err        <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      x_done <= 1'b0;

      // A timeout in the same cycle as err_clr must not be lost
      if (timeout)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (|req_vec) begin
            state      <= ST_ISSUE;
            owner      <= win_own;
            i_gnt      <= win[OWN_I];
            d_gnt      <= win[OWN_D];
            x_gnt      <= win[OWN_X];
            push_phase <= win[OWN_D] && d_push;
            fill_tag   <= d_tag;
            q_write    <= sel_write;
            q_i_d      <= win[OWN_I];
            q_paddr    <= sel_tag;
            q_mem      <= mem_sel(rom_mode, sel_tag[TW-1], sel_write);
            for (int k = 0; k < 3; k++) begin
              if (win[k])
                age_q[k] <= '0;
              else if (req_vec[k] && (age_q[k] < AGE_W'(AGE_MAX)))
                age_q[k] <= age_q[k] + AGE_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          // The pull phase already raised q_req from PUSH_DONE, so here the pulse
          // either starts (fresh grant) or ends (pull) -- it is never two cycles.
          q_req <= !q_req;
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          q_req <= 1'b0;
          if (q_ack && push_phase) begin
            push_phase <= 1'b0;
            state      <= ST_PUSH_DONE;
          end else if (q_ack || timeout) begin
            state  <= ST_DONE;
            i_done <= (owner == OWN_I);
            d_done <= (owner == OWN_D);
            x_done <= (owner == OWN_X);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_PUSH_DONE: begin
          // Grant stays with D: switch the registered request to the fill read
          q_paddr <= fill_tag;
          q_write <= 1'b0;
          q_mem   <= mem_sel(rom_mode, fill_tag[TW-1], 1'b0);
          q_req   <= 1'b1;
          state   <= ST_ISSUE;
        end
        ST_DONE: begin
          i_gnt <= 1'b0;
          d_gnt <= 1'b0;
          x_gnt <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
